// File: rtl/ewh_pkg.sv
// Shared types and constants for the photodiode hit path.
package ewh_pkg;

    localparam logic [3:0] NO_TARGET = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        QUAL_HI,
        LIT,
        QUAL_LO
    } chan_state_e;

    typedef logic [3:0] sensor_idx_t;

endpackage

// File: rtl/photo_debounce_channel.sv
// One photodiode channel: 2-flop synchroniser, level debouncer and a
// registered one-cycle strike pulse per qualified illumination.
module photo_debounce_channel
    import ewh_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic photo_i,
    output logic strike_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strike_q, strike_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            strike_q <= 1'b0;
        end else begin
            sync1_q  <= photo_i;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strike_q <= strike_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = QUAL_HI;
                    cnt_d   = CW'(1);
                end
            end
            QUAL_HI: begin
                if (sync2_q) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = LIT;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            LIT: begin
                if (!sync2_q) begin
                    state_d = QUAL_LO;
                    cnt_d   = CW'(1);
                end
            end
            QUAL_LO: begin
                if (!sync2_q) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = IDLE;
                end else begin
                    state_d = LIT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strike fires on the QUAL_HI -> LIT transition only; QUAL_LO -> LIT is silent.
    always_comb begin
        strike_d = (state_q == QUAL_HI) && sync2_q && (cnt_q == CNT_LAST);
    end

    assign strike_o = strike_q;

endmodule

// File: rtl/photo_hit_detector.sv
// Photodiode hit detector: per-channel debounce, pending-bit merge, event
// FIFO with valid/ready head and sticky per-target hit flags.
module photo_hit_detector
    import ewh_pkg::*;
#(
    parameter int unsigned NUM_SENSORS     = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] photo_array,
    input  logic [3:0]             target_a,
    input  logic [3:0]             target_b,
    output logic                   hit_valid,
    output logic [3:0]             hit_index,
    input  logic                   hit_ready,
    output logic                   hit_a,
    output logic                   hit_b
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [NUM_SENSORS-1:0] strike;
    logic [NUM_SENSORS-1:0] pending_q, pending_d, grant_mask;
    logic                   grant_vld;
    sensor_idx_t            grant_idx;

    sensor_idx_t            mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   full, push, pop;

    logic [3:0]             target_a_prev_q, target_b_prev_q;
    logic                   hit_a_q, hit_a_d, hit_b_q, hit_b_d;
    logic                   strike_a, strike_b;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_chan
        photo_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_i   (clock),
            .rst_i   (reset),
            .photo_i (photo_array[g]),
            .strike_o(strike[g])
        );
    end

    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_mask = '0;
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
            if (!grant_vld && pending_q[i]) begin
                grant_vld     = 1'b1;
                grant_idx     = sensor_idx_t'(i);
                grant_mask[i] = 1'b1;
            end
        end
    end

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && hit_ready;
    assign push = grant_vld && (!full || pop);

    // A strike on an already pending channel merges into the same bit.
    assign pending_d = (pending_q & ~(push ? grant_mask : '0)) | strike;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        strike_a = 1'b0;
        strike_b = 1'b0;
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
            if (strike[i] && target_a == sensor_idx_t'(i)) strike_a = 1'b1;
            if (strike[i] && target_b == sensor_idx_t'(i)) strike_b = 1'b1;
        end
        hit_a_d = hit_a_q;
        hit_b_d = hit_b_q;
        if (target_a != target_a_prev_q) hit_a_d = 1'b0;
        else if (strike_a)                hit_a_d = 1'b1;
        if (target_b != target_b_prev_q) hit_b_d = 1'b0;
        else if (strike_b)                hit_b_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q       <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            target_a_prev_q <= '0;
            target_b_prev_q <= '0;
            hit_a_q         <= 1'b0;
            hit_b_q         <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pending_q       <= pending_d;
            count_q         <= count_d;
            target_a_prev_q <= target_a;
            target_b_prev_q <= target_b;
            hit_a_q         <= hit_a_d;
            hit_b_q         <= hit_b_d;
            if (push) begin
                mem_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign hit_valid = (count_q != '0);
    assign hit_index = mem_q[rd_ptr_q];
    assign hit_a     = hit_a_q;
    assign hit_b     = hit_b_q;

endmodule

// File: tb/tb_photo_hit_detector.sv
// Scoreboard bench for photo_hit_detector: expected event indices are queued
// when stimulus is driven and compared as the DUT hands events over.
module tb_photo_hit_detector;

    localparam int unsigned N = 10;
    localparam int unsigned D = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] photo_array;
    logic [3:0]   target_a, target_b;
    logic         hit_valid, hit_ready, hit_a, hit_b;
    logic [3:0]   hit_index;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    photo_hit_detector #(
        .NUM_SENSORS    (N),
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .photo_array(photo_array),
        .target_a   (target_a),
        .target_b   (target_b),
        .hit_valid  (hit_valid),
        .hit_index  (hit_index),
        .hit_ready  (hit_ready),
        .hit_a      (hit_a),
        .hit_b      (hit_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Inputs change 2 time units after a rising edge; outputs read there too.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // A handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clock) begin
        if (!reset && hit_valid && hit_ready) begin
            if (exp_q.size() == 0) chk("unexpected_event", 32'(hit_index), 32'hFFFF_FFFF);
            else                   chk("event_index", 32'(hit_index), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        photo_array = '0;
        target_a    = 4'hF;
        target_b    = 4'hF;
        hit_ready   = 1'b0;
        tick(3);
        chk("rst_valid", hit_valid, 0);
        chk("rst_index", hit_index, 0);
        chk("rst_hit_a", hit_a, 0);
        chk("rst_hit_b", hit_b, 0);
        reset = 1'b0;

        // single hit with exact latency
        target_a  = 4'd3;
        hit_ready = 1'b1;
        tick(3);
        photo_array[3] = 1'b1;
        exp_q.push_back(3);
        tick(6);
        chk("single_hit_a_e5", hit_a, 0);
        chk("single_valid_e5", hit_valid, 0);
        tick(1);
        chk("single_hit_a_e6", hit_a, 1);
        chk("single_valid_e6", hit_valid, 0);
        tick(1);
        chk("single_valid_e7", hit_valid, 1);
        chk("single_index_e7", hit_index, 3);
        tick(1);
        chk("single_valid_e8", hit_valid, 0);
        tick(2);
        photo_array[3] = 1'b0;
        tick(10);

        // glitch rejection, both directions
        photo_array[5] = 1'b1;
        tick(3);
        photo_array[5] = 1'b0;
        tick(10);
        chk("glitch_hi_valid", hit_valid, 0);
        photo_array[8] = 1'b1;
        exp_q.push_back(8);
        tick(12);
        photo_array[8] = 1'b0;
        tick(3);
        photo_array[8] = 1'b1;
        tick(12);
        photo_array[8] = 1'b0;
        tick(12);
        chk("glitch_no_extra", exp_q.size(), 0);
        chk("glitch_hit_a_hold", hit_a, 1);

        // simultaneous strikes drain in ascending order
        hit_ready = 1'b0;
        photo_array[7] = 1'b1;
        photo_array[2] = 1'b1;
        photo_array[9] = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(7);
        exp_q.push_back(9);
        tick(10);
        chk("simul_valid", hit_valid, 1);
        chk("simul_head", hit_index, 2);
        tick(3);
        chk("simul_head_stable", hit_index, 2);
        hit_ready = 1'b1;
        wait_drain(20);
        photo_array = '0;
        tick(10);

        // overfill: four queued, two stall as pending
        hit_ready = 1'b0;
        foreach (photo_array[i]) begin
            if (i == 0 || i == 1 || i == 4 || i == 6 || i == 8 || i == 9)
                photo_array[i] = 1'b1;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (photo_array[i]) exp_q.push_back(i);
        end
        tick(12);
        chk("full_valid", hit_valid, 1);
        chk("full_head", hit_index, 0);
        hit_ready = 1'b1;
        wait_drain(30);
        photo_array = '0;
        tick(10);

        // clear wins over a coincident strike, then re-arm on new target
        chk("clr_pre_hit_a", hit_a, 1);
        photo_array[3] = 1'b1;
        exp_q.push_back(3);
        tick(6);
        target_a = 4'd6;
        tick(1);
        chk("clr_wins", hit_a, 0);
        photo_array[3] = 1'b0;
        tick(10);
        chk("clr_stays", hit_a, 0);
        photo_array[6] = 1'b1;
        exp_q.push_back(6);
        tick(8);
        chk("rearm_hit_a", hit_a, 1);
        photo_array[6] = 1'b0;
        tick(10);
        chk("rearm_no_left", exp_q.size(), 0);

        // reset with queued events and a lit channel
        hit_ready = 1'b0;
        target_a  = 4'd4;
        target_b  = 4'd4;
        tick(2);
        photo_array[1] = 1'b1;
        photo_array[4] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(4);
        tick(10);
        chk("pre_rst_hit_a", hit_a, 1);
        chk("pre_rst_hit_b", hit_b, 1);
        chk("pre_rst_valid", hit_valid, 1);
        photo_array[1] = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        tick(1);
        chk("post_rst_valid", hit_valid, 0);
        chk("post_rst_hit_a", hit_a, 0);
        chk("post_rst_hit_b", hit_b, 0);
        chk("post_rst_index", hit_index, 0);
        reset     = 1'b0;
        hit_ready = 1'b1;
        exp_q.push_back(4);
        tick(7);
        chk("rearm_valid_e6", hit_valid, 0);
        chk("rearm_hit_a_e6", hit_a, 1);
        chk("rearm_hit_b_e6", hit_b, 1);
        tick(1);
        chk("rearm_valid_e7", hit_valid, 1);
        chk("rearm_index_e7", hit_index, 4);
        wait_drain(20);
        photo_array = '0;
        tick(12);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_valid", hit_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/photo_hit_detector.md
# photo_hit_detector

Receiving end of the glove-laser link: qualifies the raw photodiode inputs and turns each genuine laser illumination into exactly one hit event. Each channel is synchronised and debounced. Qualified strikes go to a small event queue with a valid/ready handshake for the processor side. The block also produces sticky per-target hit flags for the two active target slots. It sits between the board photodiode pins and the regfile hit-flag inputs, and replaces the free-running SR latches on that path.

## Interface
Parameters:
- NUM_SENSORS, 10: photodiode channels; index width fixed at 4 bits.
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples required to qualify a rising or falling level, ≥2.
- FIFO_DEPTH, 4: hit event queue entries, power of 2.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- photo_array  in  NUM_SENSORS  raw photodiode levels, asynchronous, 1 = lit.
- target_a  in  4  active target index, slot A; values ≥ NUM_SENSORS mean no target.
- target_b  in  4  active target index, slot B; same encoding.
- hit_valid  out  1  queue head valid.
- hit_index  out  4  channel index at queue head.
- hit_ready  in  1  consumer accepts head.
- hit_a  out  1  sticky: the slot A target was struck since target_a last changed.
- hit_b  out  1  sticky: same for slot B.

## Operation
- Synchronisation: 2-flop synchroniser per bit.
- Per-channel FSM, with a counter of width $clog2(DEBOUNCE_CYCLES+1):
  - IDLE: sync=1 → QUAL_HI, cnt=1.
  - QUAL_HI: sync=1 → cnt++; on reaching DEBOUNCE_CYCLES → LIT and a one-cycle strike pulse. sync=0 → IDLE.
  - LIT: sync=0 → QUAL_LO, cnt=1.
  - QUAL_LO: sync=0 → cnt++; on reaching DEBOUNCE_CYCLES → IDLE. sync=1 → LIT with no new strike.
  - Result: one strike per illumination; glitches shorter than DEBOUNCE_CYCLES are ignored in both directions.
- Pending vector:
  - A strike sets pending[i].
  - Each cycle, if the FIFO is not full, the lowest-index pending bit is pushed and cleared.
  - A strike on an already pending channel merges; no duplicate is queued.
  - A full FIFO stalls the pending bits; no event is lost except by merge.
- FIFO:
  - hit_valid = non-empty; hit_index = head entry.
  - Pop when hit_valid & hit_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full, since the pop frees a slot.
  - hit_valid falls only after the last entry is popped.
- Sticky flags:
  - The block registers target_a_prev and target_b_prev each cycle.
  - hit_a is set by a strike on channel target_a when target_a < NUM_SENSORS.
  - hit_a is cleared when target_a ≠ target_a_prev. If both happen in one cycle, clear wins.
  - hit_b behaves the same way for slot B.
  - If target_a == target_b, one strike sets both flags.
- Reset values:
  - Synchronisers 0; all channels IDLE with cnt 0; pending 0.
  - FIFO empty; hit_valid 0; hit_index 0.
  - hit_a 0; hit_b 0; target_*_prev 0.
  - Reset mid-qualification or with the queue non-empty discards everything.
  - A photodiode still lit after reset requalifies from IDLE and produces one fresh strike.

## Timing
- Edge counting: edge 0 is the first clock edge that samples photo_array[i] high.
  - Synchroniser output high after edge 1.
  - LIT and strike after edge 1+DEBOUNCE_CYCLES.
  - hit_a/hit_b set after edge 2+DEBOUNCE_CYCLES.
  - pending set on that same edge.
  - hit_valid after edge 3+DEBOUNCE_CYCLES.
- Multiple simultaneous strikes drain one per cycle in ascending index order.
- hit_index is stable while hit_valid=1 and hit_ready=0.
- Sticky-flag clear takes effect on the edge after target_* changes.

## Structure
- Shared package ewh_pkg holds:
  - NO_TARGET = 4'hF.
  - The channel state enum {IDLE, QUAL_HI, LIT, QUAL_LO}.
  - The 4-bit sensor index typedef.
- Sub-module photo_debounce_channel holds the synchroniser, FSM and counter, and outputs the strike pulse. It is generated NUM_SENSORS times.
- The top level holds the pending vector, priority encoder, FIFO and sticky flags.

## Test plan
- Single hit: ch 3 held high for 10 cycles, target_a=3, hit_ready=1 → hit_a rises after edge 6, hit_valid for one cycle after edge 7 with hit_index=3. Exactly one event.
- Glitch rejection: ch 5 pulses high for 3 cycles, and separately a lit channel drops low for 3 cycles → no new event, hit flags unchanged.
- Simultaneous: ch 7, 2 and 9 rise on the same cycle with hit_ready=0 → queue holds 2, 7, 9; hit_index=2. After hit_ready rises, pops return 2, 7, 9.
- Full queue: 6 channels strike with hit_ready=0 → FIFO holds the 4 lowest indices and 2 bits stay pending. Draining yields all 6 in ascending order; simultaneous push/pop when full loses nothing.
- Flag clear: hit_a=1, target_a changes 3→6 on the same cycle as a strike on ch 3 → hit_a=0. A later strike on ch 6 → hit_a=1.
- Reset: reset pulsed with 2 queued events and ch 4 still lit → hit_valid=0 and hit_a=hit_b=0 after the reset edge. Ch 4 then re-reports once, DEBOUNCE_CYCLES+4 edges after reset deasserts.
